// File: rtl/svc_soc_io_arb_pkg.sv
// -----------------------------------------------------------------------------
// svc_soc_io_arb_pkg
// Shared types and constants for the SoC I/O arbiter.
//   arb_state_t : M1 request FSM states (IDLE, WAIT, RESP)
//   RD_LAT_MAX  : largest downstream read latency the response pipe supports
//   RSP_CNT_W   : width of the response countdown counter
// -----------------------------------------------------------------------------
package svc_soc_io_arb_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      RESP = 2'd2
   } arb_state_t;

   localparam int RD_LAT_MAX = 4;
   localparam int RSP_CNT_W  = $clog2(RD_LAT_MAX + 1);

endpackage

// File: rtl/svc_soc_io_arb_rsp.sv
// -----------------------------------------------------------------------------
// svc_soc_io_arb_rsp
// Response pipe for M1 reads. A start pulse loads a countdown with RD_LAT; when
// the count reaches its last step the downstream data is valid, so it is
// captured and a one-cycle rvalid pulse is produced alongside it.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   start      : M1 read accepted this cycle
//   io_rdata   : downstream read data
//   rvalid     : registered one-cycle response valid
//   rdata      : registered captured read data
// -----------------------------------------------------------------------------
module svc_soc_io_arb_rsp
   import svc_soc_io_arb_pkg::*;
#(
   parameter int DW     = 32,
   parameter int RD_LAT = 1
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          start,
   input  logic [DW-1:0] io_rdata,
   output logic          rvalid,
   output logic [DW-1:0] rdata
);

   localparam logic [RSP_CNT_W-1:0] CNT_LOAD = RSP_CNT_W'(RD_LAT);
   localparam logic [RSP_CNT_W-1:0] CNT_ONE  = RSP_CNT_W'(1);

   logic [RSP_CNT_W-1:0] cnt;

   // Countdown from RD_LAT; the cycle holding count 1 is the one in which the
   // downstream data is valid, so it is sampled at the end of that cycle and
   // rvalid is raised for exactly the following cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt    <= '0;
         rvalid <= 1'b0;
         rdata  <= '0;
      end else begin
         rvalid <= 1'b0;
         if (start) begin
            cnt <= CNT_LOAD;
         end else if (cnt != '0) begin
            cnt <= cnt - CNT_ONE;
            if (cnt == CNT_ONE) begin
               rvalid <= 1'b1;
               rdata  <= io_rdata;
            end
         end
      end
   end

endmodule

// File: rtl/svc_soc_io_arb.sv
// -----------------------------------------------------------------------------
// svc_soc_io_arb
// Two-requester arbiter in front of the SoC I/O register bank. The CPU always
// wins its channel and is never stalled; the secondary master M1 (debug loader
// or DMA) is slotted into cycles where the CPU leaves the needed channel idle.
// Ports:
//   clk, rst_n          : clock, asynchronous active-low reset
//   cpu_ren/raddr/rdata : CPU read channel (rdata passed straight through)
//   cpu_wen/waddr/wdata/wstrb : CPU write channel
//   m1_valid/ready/we/addr/wdata/wstrb : M1 request handshake
//   m1_rvalid/rdata     : M1 read response (one-cycle pulse)
//   m1_starve           : M1 blocked for STARVE_LIMIT consecutive cycles
//   io_*                : downstream read and write channels
// Optional build macro SVC_SOC_IO_ARB_STATS_EN adds stat_m1_grants and
// stat_m1_blocked free-running 32-bit counters.
// -----------------------------------------------------------------------------
module svc_soc_io_arb
   import svc_soc_io_arb_pkg::*;
#(
   parameter int AW           = 32,
   parameter int DW           = 32,
   parameter int RD_LAT       = 1,
   parameter int STARVE_LIMIT = 64
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            cpu_ren,
   input  logic [AW-1:0]   cpu_raddr,
   output logic [DW-1:0]   cpu_rdata,
   input  logic            cpu_wen,
   input  logic [AW-1:0]   cpu_waddr,
   input  logic [DW-1:0]   cpu_wdata,
   input  logic [DW/8-1:0] cpu_wstrb,
   input  logic            m1_valid,
   output logic            m1_ready,
   input  logic            m1_we,
   input  logic [AW-1:0]   m1_addr,
   input  logic [DW-1:0]   m1_wdata,
   input  logic [DW/8-1:0] m1_wstrb,
   output logic            m1_rvalid,
   output logic [DW-1:0]   m1_rdata,
   output logic            m1_starve,
   output logic            io_ren,
   output logic [AW-1:0]   io_raddr,
   input  logic [DW-1:0]   io_rdata,
   output logic            io_wen,
   output logic [AW-1:0]   io_waddr,
   output logic [DW-1:0]   io_wdata,
   output logic [DW/8-1:0] io_wstrb
`ifdef SVC_SOC_IO_ARB_STATS_EN
   ,
   output logic [31:0]     stat_m1_grants,
   output logic [31:0]     stat_m1_blocked
`endif
);

   localparam logic [15:0] STARVE_MAX = 16'(STARVE_LIMIT);

   arb_state_t  state;
   logic        m1_free;
   logic        in_resp;
   logic        m1_blocked;
   logic        m1_wgrant;
   logic        m1_rgrant;
   logic [15:0] starve_cnt;
   logic [15:0] starve_next;

   assign cpu_rdata  = io_rdata;
   assign in_resp    = (state == RESP);
   assign m1_free    = m1_we ? !cpu_wen : !cpu_ren;
   assign m1_ready   = m1_valid & m1_free & !in_resp;
   assign m1_blocked = m1_valid & !m1_ready & !in_resp;
   assign m1_wgrant  = m1_ready & m1_we;
   assign m1_rgrant  = m1_ready & !m1_we;

   // Downstream channel muxes. A grant to M1 already implies the CPU is idle
   // on that channel, so the grant alone selects the M1 fields.
   always_comb begin
      io_wen   = cpu_wen | m1_wgrant;
      io_waddr = cpu_waddr;
      io_wdata = cpu_wdata;
      io_wstrb = cpu_wstrb;
      io_ren   = cpu_ren | m1_rgrant;
      io_raddr = cpu_raddr;
      if (m1_wgrant) begin
         io_waddr = m1_addr;
         io_wdata = m1_wdata;
         io_wstrb = m1_wstrb;
      end
      if (m1_rgrant) begin
         io_raddr = m1_addr;
      end
   end

   // M1 request FSM. RESP is held through the rvalid cycle so the next M1
   // request can only be accepted the cycle after the response pulse.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         case (state)
            IDLE, WAIT: begin
               if (m1_ready)
                  state <= m1_we ? IDLE : RESP;
               else if (m1_valid)
                  state <= WAIT;
               else
                  state <= IDLE;
            end
            RESP: begin
               if (m1_rvalid)
                  state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Starvation counter: saturating count of consecutive blocked cycles,
   // cleared by any accept. The flag is registered from the next count so it
   // rises the cycle after the limit-th blocked cycle.
   always_comb begin
      starve_next = starve_cnt;
      if (m1_ready)
         starve_next = '0;
      else if (m1_blocked && starve_cnt != STARVE_MAX)
         starve_next = starve_cnt + 16'd1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         starve_cnt <= '0;
         m1_starve  <= 1'b0;
      end else begin
         starve_cnt <= starve_next;
         m1_starve  <= (starve_next == STARVE_MAX);
      end
   end

   svc_soc_io_arb_rsp #(
      .DW     (DW),
      .RD_LAT (RD_LAT)
   ) u_rsp (
      .clk      (clk),
      .rst_n    (rst_n),
      .start    (m1_rgrant),
      .io_rdata (io_rdata),
      .rvalid   (m1_rvalid),
      .rdata    (m1_rdata)
   );

`ifdef SVC_SOC_IO_ARB_STATS_EN
   // Free-running statistics; both wrap naturally at 2^32.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stat_m1_grants  <= '0;
         stat_m1_blocked <= '0;
      end else begin
         if (m1_ready)
            stat_m1_grants <= stat_m1_grants + 32'd1;
         if (m1_blocked)
            stat_m1_blocked <= stat_m1_blocked + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_svc_soc_io_arb.sv
// -----------------------------------------------------------------------------
// tb_svc_soc_io_arb
// Directed bench for svc_soc_io_arb with RD_LAT=1 and STARVE_LIMIT=4. Inputs
// are staged in pending variables and committed on the falling clock edge;
// outputs are compared 1 ns later. A small downstream model answers reads one
// cycle after io_ren.
// -----------------------------------------------------------------------------
module tb_svc_soc_io_arb;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        cpu_ren;
   logic [31:0] cpu_raddr;
   logic [31:0] cpu_rdata;
   logic        cpu_wen;
   logic [31:0] cpu_waddr;
   logic [31:0] cpu_wdata;
   logic [3:0]  cpu_wstrb;
   logic        m1_valid;
   logic        m1_ready;
   logic        m1_we;
   logic [31:0] m1_addr;
   logic [31:0] m1_wdata;
   logic [3:0]  m1_wstrb;
   logic        m1_rvalid;
   logic [31:0] m1_rdata;
   logic        m1_starve;
   logic        io_ren;
   logic [31:0] io_raddr;
   logic [31:0] io_rdata = 32'h0;
   logic        io_wen;
   logic [31:0] io_waddr;
   logic [31:0] io_wdata;
   logic [3:0]  io_wstrb;
`ifdef SVC_SOC_IO_ARB_STATS_EN
   logic [31:0] stat_m1_grants;
   logic [31:0] stat_m1_blocked;
`endif

   logic        p_cpu_ren;
   logic [31:0] p_cpu_raddr;
   logic        p_cpu_wen;
   logic [31:0] p_cpu_waddr;
   logic [31:0] p_cpu_wdata;
   logic [3:0]  p_cpu_wstrb;
   logic        p_m1_valid;
   logic        p_m1_we;
   logic [31:0] p_m1_addr;
   logic [31:0] p_m1_wdata;
   logic [3:0]  p_m1_wstrb;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   svc_soc_io_arb #(
      .AW           (32),
      .DW           (32),
      .RD_LAT       (1),
      .STARVE_LIMIT (4)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .cpu_ren   (cpu_ren),
      .cpu_raddr (cpu_raddr),
      .cpu_rdata (cpu_rdata),
      .cpu_wen   (cpu_wen),
      .cpu_waddr (cpu_waddr),
      .cpu_wdata (cpu_wdata),
      .cpu_wstrb (cpu_wstrb),
      .m1_valid  (m1_valid),
      .m1_ready  (m1_ready),
      .m1_we     (m1_we),
      .m1_addr   (m1_addr),
      .m1_wdata  (m1_wdata),
      .m1_wstrb  (m1_wstrb),
      .m1_rvalid (m1_rvalid),
      .m1_rdata  (m1_rdata),
      .m1_starve (m1_starve),
      .io_ren    (io_ren),
      .io_raddr  (io_raddr),
      .io_rdata  (io_rdata),
      .io_wen    (io_wen),
      .io_waddr  (io_waddr),
      .io_wdata  (io_wdata),
      .io_wstrb  (io_wstrb)
`ifdef SVC_SOC_IO_ARB_STATS_EN
      ,
      .stat_m1_grants  (stat_m1_grants),
      .stat_m1_blocked (stat_m1_blocked)
`endif
   );

   // Downstream register bank model: fixed contents at two addresses and an
   // address-derived pattern elsewhere, returned one cycle after io_ren.
   function automatic logic [31:0] rdModel(input logic [31:0] addr);
      case (addr)
         32'h20:  return 32'h1234_5678;
         32'h30:  return 32'hCAFE_0030;
         default: return addr ^ 32'h5A5A_0000;
      endcase
   endfunction

   always @(posedge clk) begin
      if (io_ren)
         io_rdata <= rdModel(io_raddr);
   end

   task automatic setCpuRead(input logic ren, input logic [31:0] addr);
      p_cpu_ren   = ren;
      p_cpu_raddr = addr;
   endtask

   task automatic setCpuWrite(input logic wen, input logic [31:0] addr,
                              input logic [31:0] data, input logic [3:0] strb);
      p_cpu_wen   = wen;
      p_cpu_waddr = addr;
      p_cpu_wdata = data;
      p_cpu_wstrb = strb;
   endtask

   task automatic setM1(input logic valid, input logic we, input logic [31:0] addr,
                        input logic [31:0] data, input logic [3:0] strb);
      p_m1_valid = valid;
      p_m1_we    = we;
      p_m1_addr  = addr;
      p_m1_wdata = data;
      p_m1_wstrb = strb;
   endtask

   // Commit the staged inputs on the falling edge and settle before sampling.
   task automatic applyStimulus();
      @(negedge clk);
      cpu_ren   = p_cpu_ren;
      cpu_raddr = p_cpu_raddr;
      cpu_wen   = p_cpu_wen;
      cpu_waddr = p_cpu_waddr;
      cpu_wdata = p_cpu_wdata;
      cpu_wstrb = p_cpu_wstrb;
      m1_valid  = p_m1_valid;
      m1_we     = p_m1_we;
      m1_addr   = p_m1_addr;
      m1_wdata  = p_m1_wdata;
      m1_wstrb  = p_m1_wstrb;
      #1;
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      checks++;
      assert (observed === expected) else begin
         failures++;
         $display("[TB] FAIL %s: observed=0x%08h expected=0x%08h", tag, observed, expected);
         $error("[TB] check %s did not match", tag);
      end
   endtask

   initial begin
      rst_n = 1'b0;
      setCpuRead(1'b0, 32'h0);
      setCpuWrite(1'b0, 32'h0, 32'h0, 4'h0);
      setM1(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
      applyStimulus();
      applyStimulus();
      checkOutput("rst_rvalid", {31'b0, m1_rvalid}, 32'd0);
      checkOutput("rst_starve", {31'b0, m1_starve}, 32'd0);
      checkOutput("rst_ready",  {31'b0, m1_ready},  32'd0);
      checkOutput("rst_rdata",  m1_rdata,           32'h0);
      checkOutput("rst_io_wen", {31'b0, io_wen},    32'd0);
      checkOutput("rst_io_ren", {31'b0, io_ren},    32'd0);
      rst_n = 1'b1;

      $display("[TB] M1 write alone");
      setM1(1'b1, 1'b1, 32'h10, 32'hA5A5_0001, 4'hF);
      applyStimulus();
      checkOutput("w_ready",  {31'b0, m1_ready}, 32'd1);
      checkOutput("w_io_wen", {31'b0, io_wen},   32'd1);
      checkOutput("w_waddr",  io_waddr,          32'h10);
      checkOutput("w_wdata",  io_wdata,          32'hA5A5_0001);
      checkOutput("w_wstrb",  {28'b0, io_wstrb}, 32'hF);
      checkOutput("w_io_ren", {31'b0, io_ren},   32'd0);
      setM1(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
      applyStimulus();
      checkOutput("w_idle_wen", {31'b0, io_wen}, 32'd0);

      $display("[TB] M1 read, response pipe");
      setM1(1'b1, 1'b0, 32'h20, 32'h0, 4'h0);
      applyStimulus();
      checkOutput("r_ready",  {31'b0, m1_ready}, 32'd1);
      checkOutput("r_io_ren", {31'b0, io_ren},   32'd1);
      checkOutput("r_raddr",  io_raddr,          32'h20);
      setM1(1'b1, 1'b1, 32'h50, 32'h0000_0050, 4'hF);
      applyStimulus();
      checkOutput("resp_ready0",  {31'b0, m1_ready},  32'd0);
      checkOutput("resp_io_wen0", {31'b0, io_wen},    32'd0);
      checkOutput("resp_rvalid0", {31'b0, m1_rvalid}, 32'd0);
      checkOutput("cpu_rdata_pt", cpu_rdata,          32'h1234_5678);
      applyStimulus();
      checkOutput("resp_rvalid1", {31'b0, m1_rvalid}, 32'd1);
      checkOutput("resp_rdata",   m1_rdata,           32'h1234_5678);
      checkOutput("resp_ready1",  {31'b0, m1_ready},  32'd0);
      applyStimulus();
      checkOutput("post_rvalid",  {31'b0, m1_rvalid}, 32'd0);
      checkOutput("post_ready",   {31'b0, m1_ready},  32'd1);
      checkOutput("post_waddr",   io_waddr,           32'h50);
      setM1(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
      applyStimulus();

      $display("[TB] CPU write contention and starvation");
      setM1(1'b1, 1'b1, 32'h70, 32'hBEEF_0070, 4'hF);
      for (int i = 1; i <= 5; i++) begin
         setCpuWrite(1'b1, 32'h60, 32'h1111_0000 + 32'(i), 4'h3);
         applyStimulus();
         checkOutput($sformatf("cont_ready_%0d", i), {31'b0, m1_ready}, 32'd0);
         checkOutput($sformatf("cont_wdata_%0d", i), io_wdata, 32'h1111_0000 + 32'(i));
         checkOutput($sformatf("cont_waddr_%0d", i), io_waddr, 32'h60);
         checkOutput($sformatf("cont_starve_%0d", i), {31'b0, m1_starve},
                     (i == 5) ? 32'd1 : 32'd0);
      end
      setCpuWrite(1'b0, 32'h0, 32'h0, 4'h0);
      applyStimulus();
      checkOutput("grant6_ready",  {31'b0, m1_ready},  32'd1);
      checkOutput("grant6_waddr",  io_waddr,           32'h70);
      checkOutput("grant6_wdata",  io_wdata,           32'hBEEF_0070);
      checkOutput("grant6_starve", {31'b0, m1_starve}, 32'd1);
      setM1(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
      applyStimulus();
      checkOutput("starve_clear", {31'b0, m1_starve}, 32'd0);

      $display("[TB] Cross-channel: CPU read with M1 write");
      setCpuRead(1'b1, 32'h30);
      setM1(1'b1, 1'b1, 32'h40, 32'h0000_4040, 4'h1);
      applyStimulus();
      checkOutput("x1_ready", {31'b0, m1_ready}, 32'd1);
      checkOutput("x1_ren",   {31'b0, io_ren},   32'd1);
      checkOutput("x1_raddr", io_raddr,          32'h30);
      checkOutput("x1_wen",   {31'b0, io_wen},   32'd1);
      checkOutput("x1_waddr", io_waddr,          32'h40);
      checkOutput("x1_wstrb", {28'b0, io_wstrb}, 32'h1);
      setCpuRead(1'b0, 32'h0);
      setM1(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
      applyStimulus();
      checkOutput("x1_cpu_rdata", cpu_rdata, 32'hCAFE_0030);

      $display("[TB] Cross-channel: CPU write with M1 read");
      setCpuWrite(1'b1, 32'h80, 32'h8080_8080, 4'hF);
      setM1(1'b1, 1'b0, 32'h24, 32'h0, 4'h0);
      applyStimulus();
      checkOutput("x2_ready", {31'b0, m1_ready}, 32'd1);
      checkOutput("x2_raddr", io_raddr,          32'h24);
      checkOutput("x2_waddr", io_waddr,          32'h80);
      checkOutput("x2_wdata", io_wdata,          32'h8080_8080);
      setCpuWrite(1'b0, 32'h0, 32'h0, 4'h0);
      setM1(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
      applyStimulus();
      applyStimulus();
      checkOutput("x2_rvalid", {31'b0, m1_rvalid}, 32'd1);
      checkOutput("x2_rdata",  m1_rdata,           32'h5A5A_0024);

      $display("[TB] CPU read holds off M1 read");
      setCpuRead(1'b1, 32'h30);
      setM1(1'b1, 1'b0, 32'h28, 32'h0, 4'h0);
      applyStimulus();
      checkOutput("rb_ready0", {31'b0, m1_ready}, 32'd0);
      checkOutput("rb_raddr0", io_raddr,          32'h30);
      setCpuRead(1'b0, 32'h0);
      applyStimulus();
      checkOutput("rb_ready1", {31'b0, m1_ready}, 32'd1);
      checkOutput("rb_raddr1", io_raddr,          32'h28);
      setM1(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
      applyStimulus();
      applyStimulus();
      checkOutput("rb_rvalid", {31'b0, m1_rvalid}, 32'd1);
      checkOutput("rb_rdata",  m1_rdata,           32'h5A5A_0028);

      $display("[TB] Reset during an M1 read");
      setM1(1'b1, 1'b0, 32'h20, 32'h0, 4'h0);
      applyStimulus();
      checkOutput("mr_ready", {31'b0, m1_ready}, 32'd1);
      setM1(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
      applyStimulus();
      rst_n = 1'b0;
      applyStimulus();
      checkOutput("mr_rst_rvalid", {31'b0, m1_rvalid}, 32'd0);
      checkOutput("mr_rst_rdata",  m1_rdata,           32'h0);
      rst_n = 1'b1;
      applyStimulus();
      checkOutput("mr_rel_rvalid1", {31'b0, m1_rvalid}, 32'd0);
      applyStimulus();
      checkOutput("mr_rel_rvalid2", {31'b0, m1_rvalid}, 32'd0);
      setM1(1'b1, 1'b0, 32'h2C, 32'h0, 4'h0);
      applyStimulus();
      checkOutput("mr_next_ready", {31'b0, m1_ready}, 32'd1);
      checkOutput("mr_next_raddr", io_raddr,          32'h2C);
      setM1(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
      applyStimulus();
      applyStimulus();
      checkOutput("mr_next_rvalid", {31'b0, m1_rvalid}, 32'd1);
      checkOutput("mr_next_rdata",  m1_rdata,           32'h5A5A_002C);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
